// File: rtl/cpu_core.sv
// Single-cycle RV32I-subset core: internal instruction ROM, word-addressed data RAM,
// and a two-array register file (file2 mirrors file1 to provide the second read port).

module cpu_regfile (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        we_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);
    logic [31:0] file1 [32];
    logic [31:0] file2 [32];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) begin
                file1[i] <= '0;
                file2[i] <= '0;
            end
        end else if (we_i && (rd_i != 5'd0)) begin
            file1[rd_i] <= wdata_i;
            file2[rd_i] <= wdata_i;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
    assign rdata1_o = (rs1_i == 5'd0) ? '0 : file1[rs1_i];
    assign rdata2_o = (rs2_i == 5'd0) ? '0 : file2[rs2_i];
endmodule

module cpu_core #(
    parameter int    IMEM_WORDS = 256,
    parameter int    DMEM_WORDS = 256,
    parameter string IMEM_FILE  = "prog.hex"
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr;
    logic [6:0]         opcode, funct7;
    logic [2:0]         funct3;
    logic [31:0]        rs1_val, rs2_val;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0]        mem_addr;
    logic [DAW-1:0]     mem_idx;
    logic               rd_we, mem_we, op_legal, opimm_legal;
    logic [31:0]        rd_wdata;

    function automatic logic [31:0] alu_f(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  alu_f = alt ? a - b : a + b;
            3'b001:  alu_f = a << b[4:0];
            3'b010:  alu_f = {31'd0, sa < sb};
            3'b011:  alu_f = {31'd0, a < b};
            3'b100:  alu_f = a ^ b;
            3'b101:  alu_f = alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'b110:  alu_f = a | b;
            default: alu_f = a & b;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  branch_taken = (a == b);
            3'b001:  branch_taken = (a != b);
            3'b100:  branch_taken = (sa < sb);
            3'b101:  branch_taken = (sa >= sb);
            3'b110:  branch_taken = (a < b);
            3'b111:  branch_taken = (a >= b);
            default: branch_taken = 1'b0;
        endcase
    endfunction

    assign instr  = imem[pc_q[IAW+1:2]];
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    cpu_regfile reg_file (
        .clk_i    (clk),
        .reset_i  (reset),
        .we_i     (rd_we),
        .rs1_i    (instr[19:15]),
        .rs2_i    (instr[24:20]),
        .rd_i     (instr[11:7]),
        .wdata_i  (rd_wdata),
        .rdata1_o (rs1_val),
        .rdata2_o (rs2_val)
    );

    // Only funct7 = 0000000 / 0100000 are legal, and the alternate form only for SUB/SRA.
    assign op_legal    = (funct7 == 7'd0) ||
                         ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    assign opimm_legal = (funct3 == 3'b001) ? (funct7 == 7'd0) :
                         (funct3 == 3'b101) ? ((funct7 == 7'd0) || (funct7 == 7'b0100000)) : 1'b1;

    assign mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign mem_idx  = mem_addr[DAW+1:2];

    always_comb begin
        rd_we    = 1'b0;
        rd_wdata = '0;
        mem_we   = 1'b0;
        pc_d     = pc_q + 32'd4;
        case (opcode)
            OPC_OP: if (op_legal) begin
                rd_we    = 1'b1;
                rd_wdata = alu_f(funct3, instr[30], rs1_val, rs2_val);
            end
            OPC_OPIMM: if (opimm_legal) begin
                rd_we    = 1'b1;
                rd_wdata = alu_f(funct3, (funct3 == 3'b101) && instr[30], rs1_val, imm_i);
            end
            OPC_LUI: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OPC_AUIPC: begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + imm_u;
            end
            OPC_JAL: begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + 32'd4;
                pc_d     = pc_q + imm_j;
            end
            OPC_JALR: if (funct3 == 3'b000) begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + 32'd4;
                pc_d     = (rs1_val + imm_i) & ~32'd1;
            end
            OPC_BRANCH: if (branch_taken(funct3, rs1_val, rs2_val)) begin
                pc_d = pc_q + imm_b;
            end
            OPC_LOAD: if (funct3 == 3'b010) begin
                rd_we    = 1'b1;
                rd_wdata = dmem[mem_idx];
            end
            OPC_STORE: if (funct3 == 3'b010) begin
                mem_we = 1'b1;
            end
            default: ;
        endcase
    end

    // Commit edge: pc update, register write (inside reg_file) and store share it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            dmem[mem_idx] <= rs2_val;
        end
    end

    assign pc_out = pc_q;
endmodule

// File: tb/tb_cpu_core.sv
// Directed programs loaded into the core's ROM; expected register/pc values are queued
// as each program is started and popped/compared after the core has stepped.

module tb_cpu_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        bit          is_pc;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] prog [$];

    cpu_core #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clk    (clk),
        .reset  (reset),
        .pc_out (pc_out)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
        logic [31:0] v;
        v = imm20;
        return {v[19:0], 5'(rd), op};
    endfunction
    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return enc_i(imm, rs1, 0, rd, 7'b0010011);
    endfunction

    task automatic exp_reg(string tag, int idx, logic [31:0] v);
        exp_t e;
        e.tag = tag; e.is_pc = 1'b0; e.idx = idx; e.exp = v;
        sb.push_back(e);
    endtask
    task automatic exp_pc(string tag, logic [31:0] v);
        exp_t e;
        e.tag = tag; e.is_pc = 1'b1; e.idx = 0; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = e.is_pc ? pc_out : dut.reg_file.file1[e.idx];
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_prog();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) dut.imem[i] = 32'd0;
        for (int i = 0; i < prog.size(); i++) dut.imem[i] = prog[i];
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        // 1: basic ADDI/ADD and reset state
        prog = {addi(1, 0, 5), addi(2, 0, 7), enc_r(0, 2, 1, 0, 3)};
        start_prog();
        exp_pc("t1_reset_pc", 32'd0);
        exp_reg("t1_reset_x1", 1, 32'd0);
        check_sb();
        exp_reg("t1_x1", 1, 32'd5);
        exp_reg("t1_x2", 2, 32'd7);
        exp_reg("t1_x3", 3, 32'd12);
        exp_pc("t1_pc", 32'd12);
        step(3);
        check_sb();

        // 2: x0 writes suppressed; uninitialised word runs as a NOP
        prog = {addi(1, 0, 3), addi(0, 0, 9), enc_r(0, 0, 0, 0, 1)};
        start_prog();
        exp_reg("t2_x1_pre", 1, 32'd3);
        exp_reg("t2_x0_pre", 0, 32'd0);
        step(2);
        check_sb();
        exp_reg("t2_x0", 0, 32'd0);
        exp_reg("t2_x1", 1, 32'd0);
        exp_pc("t2_pc", 32'd16);
        step(2);
        check_sb();

        // 3: signed vs unsigned compare
        prog = {addi(1, 0, -1), enc_r(0, 0, 1, 2, 2), enc_r(0, 0, 1, 3, 3)};
        start_prog();
        exp_reg("t3_x1", 1, 32'hFFFF_FFFF);
        exp_reg("t3_slt", 2, 32'd1);
        exp_reg("t3_sltu", 3, 32'd0);
        step(3);
        check_sb();

        // 4: countdown loop, pc traced each edge
        prog = {addi(1, 0, 3), addi(1, 1, -1), enc_b(-4, 0, 1, 1)};
        start_prog();
        begin
            int pcs [7] = '{4, 8, 4, 8, 4, 8, 12};
            for (int i = 0; i < 7; i++) begin
                exp_pc($sformatf("t4_pc_%0d", i), 32'(pcs[i]));
                step(1);
                check_sb();
            end
        end
        exp_reg("t4_x1", 1, 32'd0);
        check_sb();

        // 5: store/load, JAL, data address wrap and ignored low bits
        prog = {addi(1, 0, 42), enc_s(8, 1, 0), enc_i(8, 0, 2, 2, 7'b0000011), enc_j(8, 3),
                32'd0, enc_i(1032, 0, 2, 4, 7'b0000011), enc_i(11, 0, 2, 5, 7'b0000011)};
        start_prog();
        exp_reg("t5_lw", 2, 32'd42);
        exp_reg("t5_jal_link", 3, 32'd16);
        exp_pc("t5_jal_pc", 32'd20);
        step(4);
        check_sb();
        exp_reg("t5_lw_wrap", 4, 32'd42);
        exp_reg("t5_lw_lowbits", 5, 32'd42);
        exp_pc("t5_pc_end", 32'd28);
        step(2);
        check_sb();

        // 6: reset mid-loop, then identical re-execution
        prog = {addi(2, 0, 7), addi(3, 0, 9), addi(1, 0, 5), addi(1, 1, -1), enc_b(-4, 0, 1, 1)};
        start_prog();
        exp_pc("t6_pc_mid", 32'd12);
        exp_reg("t6_x1_mid", 1, 32'd4);
        step(5);
        check_sb();
        reset = 1'b1;
        exp_pc("t6_rst_pc", 32'd0);
        exp_reg("t6_rst_x1", 1, 32'd0);
        exp_reg("t6_rst_x2", 2, 32'd0);
        exp_reg("t6_rst_x3", 3, 32'd0);
        step(1);
        reset = 1'b0;
        check_sb();
        exp_pc("t6_rerun_mid", 32'd12);
        exp_reg("t6_rerun_x1_mid", 1, 32'd4);
        step(5);
        check_sb();
        exp_pc("t6_pc_end", 32'd20);
        exp_reg("t6_x1_end", 1, 32'd0);
        exp_reg("t6_x2_end", 2, 32'd7);
        exp_reg("t6_x3_end", 3, 32'd9);
        step(8);
        check_sb();

        // 7: ALU ops, U-type, JALR masking, every branch kind, illegal opcodes
        prog = {addi(1, 0, -8), addi(2, 0, 3),
                enc_r(32, 2, 1, 5, 3), enc_r(0, 2, 1, 5, 4), enc_r(0, 2, 2, 1, 5),
                enc_r(32, 1, 2, 0, 6), enc_r(0, 2, 1, 7, 7), enc_r(0, 2, 1, 6, 8),
                enc_r(0, 2, 1, 4, 9), enc_u(32'h12345, 10, 7'b0110111), enc_u(1, 11, 7'b0010111),
                enc_i(-1, 1, 4, 12, 7'b0010011), enc_i(-7, 1, 2, 13, 7'b0010011),
                enc_i(5, 1, 3, 14, 7'b0010011), enc_i(32'h401, 1, 5, 15, 7'b0010011),
                enc_i(28, 1, 5, 16, 7'b0010011), enc_i(30, 2, 1, 17, 7'b0010011),
                enc_i(32'h55, 0, 6, 18, 7'b0010011), enc_i(32'hF0, 1, 7, 19, 7'b0010011),
                enc_i(89, 0, 0, 20, 7'b1100111), addi(21, 0, 1), addi(21, 0, 2),
                enc_b(8, 2, 1, 4), addi(22, 0, 1), enc_b(8, 2, 1, 5), enc_b(8, 2, 1, 6),
                enc_b(8, 2, 1, 7), addi(23, 0, 1), enc_b(8, 2, 2, 0), addi(24, 0, 1),
                32'h0000_0073, 32'hFFFF_FFFF, addi(25, 0, 1)};
        start_prog();
        exp_reg("t7_sra", 3, 32'hFFFF_FFFF);
        exp_reg("t7_srl", 4, 32'h1FFF_FFFF);
        exp_reg("t7_sll", 5, 32'd24);
        exp_reg("t7_sub", 6, 32'd11);
        exp_reg("t7_and", 7, 32'd0);
        exp_reg("t7_or", 8, 32'hFFFF_FFFB);
        exp_reg("t7_xor", 9, 32'hFFFF_FFFB);
        exp_reg("t7_lui", 10, 32'h1234_5000);
        exp_reg("t7_auipc", 11, 32'h0000_1028);
        exp_reg("t7_xori", 12, 32'd7);
        exp_reg("t7_slti", 13, 32'd1);
        exp_reg("t7_sltiu", 14, 32'd0);
        exp_reg("t7_srai", 15, 32'hFFFF_FFFC);
        exp_reg("t7_srli", 16, 32'h0000_000F);
        exp_reg("t7_slli", 17, 32'hC000_0000);
        exp_reg("t7_ori", 18, 32'h55);
        exp_reg("t7_andi", 19, 32'hF0);
        exp_reg("t7_jalr_link", 20, 32'd80);
        exp_reg("t7_jalr_skip", 21, 32'd0);
        exp_reg("t7_blt_skip", 22, 32'd0);
        exp_reg("t7_bgeu_skip", 23, 32'd0);
        exp_reg("t7_beq_skip", 24, 32'd0);
        exp_reg("t7_after_illegal", 25, 32'd1);
        exp_pc("t7_pc_end", 32'd132);
        step(28);
        check_sb();

        // 8: instruction ROM address wrap
        prog = {enc_j(1020, 0)};
        repeat (254) prog.push_back(32'd0);
        prog.push_back(addi(1, 1, 1));
        start_prog();
        exp_pc("t8_pc_jump", 32'd1020);
        step(1);
        check_sb();
        exp_reg("t8_x1", 1, 32'd2);
        exp_pc("t8_pc_end", 32'd2048);
        step(3);
        check_sb();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
